stepper_line_sequencer: RTL and testbench

APB3 slave that draws straight line segments on the two-axis whiteboard plotter by sequencing step/dir pulses for both stepper drivers. Software writes a signed (dx, dy) segment. The block runs Bresenham interpolation, emitting one step slot per major-axis step, and keeps a running position. It sits on the APB3 bus and drives the stepper driver pins directly, which removes per-step CPU writes.

---
 rtl/stepper_line_sequencer_if.sv | 22 ++
 rtl/stepper_line_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_stepper_line_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stepper_line_sequencer_if.sv
// APB3 slave-side bus bundle for stepper_line_sequencer.
// Clock and reset stay plain ports on the block.
interface stepper_line_sequencer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/stepper_line_sequencer.sv
// APB3 Bresenham line sequencer driving two step/dir stepper drivers.
// Define STEPPER_SEQ_FIFO_EN for a 4-deep command queue; otherwise a single command register.
module stepper_line_sequencer #(
  parameter int unsigned SLOT    = 202,
  parameter int unsigned SETUP   = 51,
  parameter int unsigned PULSE_W = 149
) (
  input  logic                     PCLK,
  input  logic                     PRESERN,
  stepper_line_sequencer_if.slave  apb,
  output logic                     step1,
  output logic                     dir1,
  output logic                     step2,
  output logic                     dir2,
  output logic                     irq
);

  localparam int unsigned CntW = $clog2(SLOT);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StFin} state_e;

  state_e r_state, w_state_nxt;

  logic [1:0]  w_addr;
  logic        w_wr, w_cmd_wr, w_ctrl_wr, w_stat_wr, w_abort;
  logic        w_push, w_pop, w_busy, w_full, w_nonempty;
  logic [31:0] w_head, w_prdata;
  logic [3:0]  w_qcount;
  logic        w_unused_paddr;

  assign w_addr     = apb.PADDR[3:2];
  assign w_wr       = apb.PSEL & apb.PWRITE & apb.PENABLE;
  assign w_cmd_wr   = w_wr & (w_addr == 2'd0);
  assign w_ctrl_wr  = w_wr & (w_addr == 2'd1);
  assign w_stat_wr  = w_wr & (w_addr == 2'd2);
  assign w_abort    = w_ctrl_wr & apb.PWDATA[0];
  assign w_push     = w_cmd_wr & ~w_full;
  assign w_pop      = (r_state == StFin);
  assign w_busy     = (r_state != StIdle) | w_nonempty;
  assign w_unused_paddr = ^{apb.PADDR[31:4], apb.PADDR[1:0]};

`ifdef STEPPER_SEQ_FIFO_EN
  logic [31:0] r_q [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;

  assign w_nonempty = (r_count != 3'd0);
  assign w_full     = (r_count == 3'd4);
  assign w_head     = r_q[r_rd_ptr];
  assign w_qcount   = {1'b0, r_count};

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wr_ptr] <= apb.PWDATA;
        r_wr_ptr      <= r_wr_ptr + 2'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count <= r_count + {2'b0, w_push} - {2'b0, w_pop};
    end
  end
`else
  logic [31:0] r_cmd;
  logic        r_valid;

  // Head stays valid until FIN, so busy also covers the held command.
  assign w_nonempty = r_valid;
  assign w_full     = w_busy;
  assign w_head     = r_cmd;
  assign w_qcount   = 4'd0;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_cmd   <= '0;
      r_valid <= 1'b0;
    end else if (w_abort) begin
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_cmd   <= apb.PWDATA;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end
`endif

  // Segment datapath
  logic [CntW-1:0] r_cnt;
  logic [15:0]     r_remaining, r_n, r_minor;
  logic [16:0]     r_err;
  logic            r_xmaj, r_dir1, r_dir2;
  logic [1:0]      r_mask;
  logic [15:0]     r_pos_x, r_pos_y;
  logic            r_done, r_ovf, r_irq_en;

  logic [15:0] w_ax, w_ay, w_n_ld, w_minor_ld, w_n_sel, w_minor_sel;
  logic [16:0] w_err_base, w_err_sub, w_err_nxt;
  logic        w_xmaj_ld, w_xmaj_sel, w_minor_step;
  logic [1:0]  w_mask_nxt;
  logic        w_slot_end, w_rise, w_in_pulse;

  always_comb begin
    w_ax       = w_head[15] ? (~w_head[15:0] + 16'd1) : w_head[15:0];
    w_ay       = w_head[31] ? (~w_head[31:16] + 16'd1) : w_head[31:16];
    w_xmaj_ld  = (w_ax >= w_ay);
    w_n_ld     = w_xmaj_ld ? w_ax : w_ay;
    w_minor_ld = w_xmaj_ld ? w_ay : w_ax;
  end

  // LOAD seeds the Bresenham step from the head command; RUN reuses the saved terms.
  always_comb begin
    w_err_base  = r_err;
    w_minor_sel = r_minor;
    w_n_sel     = r_n;
    w_xmaj_sel  = r_xmaj;
    if (r_state == StLoad) begin
      w_err_base  = {2'b00, w_n_ld[15:1]};
      w_minor_sel = w_minor_ld;
      w_n_sel     = w_n_ld;
      w_xmaj_sel  = w_xmaj_ld;
    end
    w_err_sub    = w_err_base - {1'b0, w_minor_sel};
    w_minor_step = w_err_sub[16];
    w_err_nxt    = w_minor_step ? (w_err_sub + {1'b0, w_n_sel}) : w_err_sub;
    w_mask_nxt   = w_xmaj_sel ? {w_minor_step, 1'b1} : {1'b1, w_minor_step};
  end

  assign w_slot_end = (r_state == StRun) && (r_cnt == CntW'(SLOT - 1));
  assign w_rise     = (r_state == StRun) && (r_cnt == CntW'(SETUP));
  assign w_in_pulse = (r_state == StRun) && (r_cnt >= CntW'(SETUP)) &&
                      (r_cnt < CntW'(SETUP + PULSE_W));

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_nonempty || w_push) w_state_nxt = StLoad;
      StLoad:  w_state_nxt = (w_n_ld == 16'd0) ? StFin : StRun;
      StRun:   if (w_slot_end && (r_remaining == 16'd1)) w_state_nxt = StFin;
      StFin:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_abort) w_state_nxt = StIdle;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_cnt       <= '0;
      r_remaining <= '0;
      r_n         <= '0;
      r_minor     <= '0;
      r_err       <= '0;
      r_xmaj      <= 1'b0;
      r_mask      <= '0;
      r_dir1      <= 1'b0;
      r_dir2      <= 1'b0;
    end else if (w_abort) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        StLoad: begin
          r_cnt       <= '0;
          r_remaining <= w_n_ld;
          r_n         <= w_n_ld;
          r_minor     <= w_minor_ld;
          r_xmaj      <= w_xmaj_ld;
          r_err       <= w_err_nxt;
          r_mask      <= w_mask_nxt;
          r_dir1      <= w_head[15];
          r_dir2      <= w_head[31];
        end
        StRun: begin
          if (w_slot_end) begin
            r_cnt       <= '0;
            r_remaining <= r_remaining - 16'd1;
            r_err       <= w_err_nxt;
            r_mask      <= w_mask_nxt;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Position counts every rise, including one truncated later by an abort.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else if (w_rise) begin
      if (r_mask[0]) r_pos_x <= r_pos_x + (r_dir1 ? 16'hFFFF : 16'h0001);
      if (r_mask[1]) r_pos_y <= r_pos_y + (r_dir2 ? 16'hFFFF : 16'h0001);
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      r_done <= (r_done & ~(w_stat_wr & apb.PWDATA[1])) | (w_pop & ~w_abort);
      r_ovf  <= (r_ovf & ~(w_stat_wr & apb.PWDATA[3])) | (w_cmd_wr & w_full);
      if (w_ctrl_wr) r_irq_en <= apb.PWDATA[1];
    end
  end

  always_comb begin
    w_prdata = '0;
    case (w_addr)
      2'd1:    w_prdata = {30'd0, r_irq_en, 1'b0};
      2'd2:    w_prdata = {24'd0, w_qcount, r_ovf, w_full, r_done, w_busy};
      2'd3:    w_prdata = {r_pos_y, r_pos_x};
      default: w_prdata = '0;
    endcase
  end

  assign apb.PRDATA  = w_prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = w_cmd_wr & w_full;

  assign step1 = w_in_pulse & r_mask[0];
  assign step2 = w_in_pulse & r_mask[1];
  assign dir1  = r_dir1;
  assign dir2  = r_dir2;
  assign irq   = r_done & r_irq_en;

endmodule

// File: tb/tb_stepper_line_sequencer.sv
// Scoreboard bench for stepper_line_sequencer: expected reads, PSLVERR and step pulses are
// queued at stimulus time and checked by independent monitors.
module tb_stepper_line_sequencer;
  localparam int SLOT    = 202;
  localparam int SETUP   = 51;
  localparam int PULSE_W = 149;
  localparam logic [31:0] A_CMD = 32'h0, A_CTRL = 32'h4, A_STAT = 32'h8, A_POS = 32'hC;

  logic PCLK    = 1'b0;
  logic PRESERN = 1'b0;
  logic step1, dir1, step2, dir2, irq;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  stepper_line_sequencer_if apb();

  stepper_line_sequencer #(.SLOT(SLOT), .SETUP(SETUP), .PULSE_W(PULSE_W)) dut (
    .PCLK   (PCLK),
    .PRESERN(PRESERN),
    .apb    (apb),
    .step1  (step1),
    .dir1   (dir1),
    .step2  (step2),
    .dir2   (dir2),
    .irq    (irq)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  logic [31:0] q_re[$];
  string       q_rn[$];
  bit          q_we[$];
  int          q1_rise[$], q1_dir[$], q1_w[$];
  int          q2_rise[$], q2_dir[$], q2_w[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_pulse(input int axis, input int rise, input int dir, input int width);
    if (axis == 1) begin
      q1_rise.push_back(rise); q1_dir.push_back(dir); q1_w.push_back(width);
    end else begin
      q2_rise.push_back(rise); q2_dir.push_back(dir); q2_w.push_back(width);
    end
  endtask

  // c_s is the negedge cycle count of the cycle after the write strobe.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit err,
                    output int c_s);
    q_we.push_back(err);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = addr; apb.PWDATA = data;
    apb.PENABLE = 1'b0;
    @(posedge PCLK); #1 apb.PENABLE = 1'b1;
    @(negedge PCLK); c_s = cyc + 1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    q_re.push_back(exp);
    q_rn.push_back(name);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = addr; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1 apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge PCLK);
  endtask

  task automatic do_reset();
    @(posedge PCLK); #1 PRESERN = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESERN = 1'b1;
  endtask

  // APB monitor
  always @(negedge PCLK) begin
    if (apb.PSEL && apb.PENABLE) begin
      if (apb.PWRITE) begin
        if (q_we.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL write unexpected: got access at cycle %0d, want none", cyc);
        end else begin
          chk("PSLVERR", {31'b0, apb.PSLVERR}, {31'b0, q_we.pop_front()});
        end
      end else begin
        if (q_re.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL read unexpected: got access at cycle %0d, want none", cyc);
        end else begin
          chk(q_rn.pop_front(), apb.PRDATA, q_re.pop_front());
        end
      end
    end
  end

  // Step pulse monitors
  bit p1 = 1'b0, p2 = 1'b0;
  int w1 = 0, w2 = 0, w1_exp = -1, w2_exp = -1;

  always @(negedge PCLK) begin
    if (step1 && !p1) begin
      w1 = 1;
      if (q1_rise.size() == 0) begin
        n_vec++; n_err++; w1_exp = -1;
        $display("FAIL step1 unexpected: got rise at cycle %0d, want none", cyc);
      end else begin
        chk("step1 rise cycle", cyc, q1_rise.pop_front());
        chk("dir1 at rise", {31'b0, dir1}, q1_dir.pop_front());
        w1_exp = q1_w.pop_front();
      end
    end else if (step1) begin
      w1++;
    end else if (p1 && w1_exp >= 0) begin
      chk("step1 width", w1, w1_exp);
    end
    p1 = step1;
  end

  always @(negedge PCLK) begin
    if (step2 && !p2) begin
      w2 = 1;
      if (q2_rise.size() == 0) begin
        n_vec++; n_err++; w2_exp = -1;
        $display("FAIL step2 unexpected: got rise at cycle %0d, want none", cyc);
      end else begin
        chk("step2 rise cycle", cyc, q2_rise.pop_front());
        chk("dir2 at rise", {31'b0, dir2}, q2_dir.pop_front());
        w2_exp = q2_w.pop_front();
      end
    end else if (step2) begin
      w2++;
    end else if (p2 && w2_exp >= 0) begin
      chk("step2 width", w2, w2_exp);
    end
    p2 = step2;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;

    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("reset pins", {27'b0, step1, dir1, step2, dir2, irq}, 32'h0);
    @(posedge PCLK); #1 PRESERN = 1'b1;
    chk("PREADY", {31'b0, apb.PREADY}, 32'h1);
    rd(A_POS,  32'h0, "POS at reset");
    rd(A_STAT, 32'h0, "STATUS at reset");
    rd(A_CTRL, 32'h0, "CTRL at reset");

    // dx=3, dy=0
    wr(A_CMD, 32'h0000_0003, 1'b0, c);
    for (int k = 0; k < 3; k++) exp_pulse(1, c + 1 + SETUP + k * SLOT, 0, PULSE_W);
`ifdef STEPPER_SEQ_FIFO_EN
    rd(A_STAT, 32'h11, "STATUS running dx3");
`else
    rd(A_STAT, 32'h05, "STATUS running dx3");
`endif
    wait_cyc(c + 3 * SLOT + 4);
    rd(A_STAT, 32'h2, "STATUS done dx3");
    rd(A_POS, 32'h0000_0003, "POS dx3");
    chk("dx3 step1 pulses left", q1_rise.size(), 0);

    // dx=-4, dy=2
    do_reset();
    wr(A_CMD, 32'h0002_FFFC, 1'b0, c);
    for (int k = 0; k < 4; k++) exp_pulse(1, c + 1 + SETUP + k * SLOT, 1, PULSE_W);
    exp_pulse(2, c + 1 + SETUP + 1 * SLOT, 0, PULSE_W);
    exp_pulse(2, c + 1 + SETUP + 3 * SLOT, 0, PULSE_W);
    wait_cyc(c + 4 * SLOT + 4);
    rd(A_POS, 32'h0002_FFFC, "POS dx-4 dy2");
    rd(A_STAT, 32'h2, "STATUS done dx-4 dy2");
    chk("dx-4 step2 pulses left", q2_rise.size(), 0);

    // Zero segment with irq, then W1C coincident with FIN
    do_reset();
    wr(A_CTRL, 32'h2, 1'b0, c);
    wr(A_CMD, 32'h0, 1'b0, c);
    wait_cyc(c + 1);
    chk("irq before done", {31'b0, irq}, 32'h0);
    wait_cyc(c + 2);
    chk("irq zero segment", {31'b0, irq}, 32'h1);
    rd(A_STAT, 32'h2, "STATUS zero segment");
    wr(A_STAT, 32'h2, 1'b0, c);
    @(negedge PCLK);
    chk("irq after W1C", {31'b0, irq}, 32'h0);
    rd(A_STAT, 32'h0, "STATUS after W1C");
    wr(A_CMD, 32'h0001_0001, 1'b0, c);
    exp_pulse(1, c + 1 + SETUP, 0, PULSE_W);
    exp_pulse(2, c + 1 + SETUP, 0, PULSE_W);
    wait_cyc(c + SLOT - 1);
    wr(A_STAT, 32'h2, 1'b0, c);
    wait_cyc(c + 3);
    rd(A_STAT, 32'h2, "STATUS W1C at FIN");
    chk("irq W1C at FIN", {31'b0, irq}, 32'h1);
    rd(A_POS, 32'h0001_0001, "POS diag");

    // Abort at slot 2 cycle 100 of a 5-step segment
    do_reset();
    wr(A_CMD, 32'h0000_0005, 1'b0, c);
    exp_pulse(1, c + 1 + SETUP, 0, PULSE_W);
    exp_pulse(1, c + 1 + SETUP + SLOT, 0, 100 - SETUP + 1);
    wait_cyc(c + 1 + SLOT + 100 - 2);
    wr(A_CTRL, 32'h1, 1'b0, c);
    @(negedge PCLK);
    chk("step1 after abort", {31'b0, step1}, 32'h0);
    rd(A_STAT, 32'h0, "STATUS after abort");
    rd(A_POS, 32'h0000_0002, "POS after abort");
    wait_cyc(cyc + 2 * SLOT);
    chk("abort pulses left", q1_rise.size(), 0);

    // Overflow
    do_reset();
`ifdef STEPPER_SEQ_FIFO_EN
    wr(A_CMD, 32'h1, 1'b0, c);
    begin
      int c2;
      for (int k = 0; k < 3; k++) wr(A_CMD, 32'h1, 1'b0, c2);
      wr(A_CMD, 32'h1, 1'b1, c2);
    end
    for (int k = 0; k < 4; k++) exp_pulse(1, c + k * (SLOT + 3) + 1 + SETUP, 0, PULSE_W);
    rd(A_STAT, 32'h4D, "STATUS fifo full");
    wait_cyc(c + 4 * (SLOT + 3) + 2);
    rd(A_STAT, 32'h0A, "STATUS fifo done");
    rd(A_POS, 32'h0000_0004, "POS fifo");
`else
    wr(A_CMD, 32'h1, 1'b0, c);
    exp_pulse(1, c + 1 + SETUP, 0, PULSE_W);
    begin
      int c2;
      wr(A_CMD, 32'h1, 1'b1, c2);
    end
    rd(A_STAT, 32'h0D, "STATUS busy overflow");
    wait_cyc(c + SLOT + 4);
    rd(A_STAT, 32'h0A, "STATUS done overflow");
    rd(A_POS, 32'h0000_0001, "POS overflow");
`endif
    wr(A_STAT, 32'h8, 1'b0, c);
    rd(A_STAT, 32'h02, "STATUS overflow W1C");

    // Reset mid-pulse
    do_reset();
    wr(A_CMD, 32'h2, 1'b0, c);
    exp_pulse(1, c + 1 + SETUP, 0, 50);
    wait_cyc(c + 1 + SETUP + 49);
    #1 PRESERN = 1'b0;
    #1 chk("step1 async reset", {31'b0, step1}, 32'h0);
    repeat (3) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    rd(A_POS, 32'h0, "POS after reset");
    rd(A_STAT, 32'h0, "STATUS after reset");
    wait_cyc(cyc + SLOT);

    chk("step1 pulses left", q1_rise.size(), 0);
    chk("step2 pulses left", q2_rise.size(), 0);
    chk("reads left", q_re.size(), 0);
    chk("writes left", q_we.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
